// File: rtl/d05200_otp_pkg.sv
// Shared types, default timing and sizing helpers for the OTP access sequencer.
package d05200_otp_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_SETUP,
    ST_READ,
    ST_PROG,
    ST_VERIFY,
    ST_RESP
  } state_e;

  // What the current SETUP/READ/PROG pass belongs to.
  typedef enum logic [1:0] {
    OP_BOOT,
    OP_RD,
    OP_PG,
    OP_VF
  } op_e;

  localparam int unsigned DEF_T_SETUP   = 2;
  localparam int unsigned DEF_T_RD      = 4;
  localparam int unsigned DEF_T_PROG    = 200;
  localparam int unsigned DEF_RETRY_MAX = 3;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/d05200_otp_timer.sv
// Loadable down-counter shared by all timed sequencer states; done marks the last cycle.
module d05200_otp_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [W-1:0] load_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= load_i - W'(1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // The start cycle is itself the first timed cycle, so a load of 1 finishes at once.
  assign done_o = start_i ? (load_i == W'(1)) : (cnt_q == W'(1));

endmodule

// File: rtl/d05200_otp_seq.sv
// OTP access sequencer: boot shadow load, then single-word read/program with verify and retry.
module d05200_otp_seq
  import d05200_otp_pkg::*;
#(
  parameter int unsigned AW        = 7,
  parameter int unsigned DW        = 8,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned SHADOW_N  = 16,
  parameter int unsigned T_SETUP   = DEF_T_SETUP,
  parameter int unsigned T_RD      = DEF_T_RD,
  parameter int unsigned T_PROG    = DEF_T_PROG,
  parameter int unsigned RETRY_MAX = DEF_RETRY_MAX
) (
  input  logic                   HCLK,
  input  logic                   RESET,
  input  logic                   req_vld,
  output logic                   req_rdy,
  input  logic                   req_wr,
  input  logic [AW-1:0]          req_addr,
  input  logic [DW-1:0]          req_wdata,
  output logic                   rsp_vld,
  output logic [DW-1:0]          rsp_rdata,
  output logic                   rsp_err,
  output logic                   boot_done,
  output logic [SHADOW_N*DW-1:0] shadow_data,
  input  logic                   vpp_ok,
  input  logic                   prog_lock,
  output logic                   OTP_CS,
  output logic                   OTP_READ,
  output logic                   OTP_PROG,
  output logic [AW-1:0]          OTP_ADDR,
  output logic [DW-1:0]          OTP_DATI,
  input  logic [DW-1:0]          OTP_DATO
);

  localparam int unsigned TW = clog2(max3(T_SETUP, T_RD, T_PROG) + 1);
  localparam int unsigned IW = clog2(SHADOW_N + 1);

  state_e                 state_q;
  op_e                    op_q;
  logic [IW-1:0]          idx_q;
  logic [2:0]             retry_q;
  logic [AW-1:0]          addr_q;
  logic [DW-1:0]          wdata_q;
  logic [DW-1:0]          rdback_q;
  logic                   tmr_start_q;
  logic [TW-1:0]          tmr_val_q;
  logic                   tmr_done;
  logic                   req_rdy_q, rsp_vld_q, rsp_err_q, boot_done_q;
  logic [DW-1:0]          rsp_rdata_q;
  logic                   cs_q, rd_q, pg_q;
  logic [AW-1:0]          adr_q;
  logic [DW-1:0]          dati_q;
  logic [SHADOW_N*DW-1:0] shadow_q;
  logic [SHADOW_N-1:0]    sh_we;
  logic [DW-1:0]          sh_wd;
  logic                   reject;

  assign reject = (32'(req_addr) >= DEPTH) || (req_wr && (prog_lock || !vpp_ok));

  d05200_otp_timer #(.W(TW)) u_timer (
    .clk_i  (HCLK),
    .rst_i  (RESET),
    .start_i(tmr_start_q),
    .load_i (tmr_val_q),
    .done_o (tmr_done)
  );

  always_ff @(posedge HCLK) begin
    if (RESET) begin
      state_q     <= ST_BOOT;
      op_q        <= OP_BOOT;
      idx_q       <= '0;
      retry_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdback_q    <= '0;
      tmr_start_q <= 1'b0;
      tmr_val_q   <= '0;
      req_rdy_q   <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      boot_done_q <= 1'b0;
      cs_q        <= 1'b0;
      rd_q        <= 1'b0;
      pg_q        <= 1'b0;
      adr_q       <= '0;
      dati_q      <= '0;
    end else begin
      tmr_start_q <= 1'b0;
      rsp_vld_q   <= 1'b0;
      case (state_q)
        ST_BOOT: begin
          if (32'(idx_q) == SHADOW_N) begin
            state_q     <= ST_IDLE;
            boot_done_q <= 1'b1;
            req_rdy_q   <= 1'b1;
          end else begin
            state_q     <= ST_SETUP;
            op_q        <= OP_BOOT;
            cs_q        <= 1'b1;
            adr_q       <= AW'(idx_q);
            tmr_start_q <= 1'b1;
            tmr_val_q   <= TW'(T_SETUP);
          end
        end
        ST_IDLE: begin
          if (req_vld && req_rdy_q) begin
            req_rdy_q <= 1'b0;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            retry_q   <= '0;
            if (reject) begin
              // Rejected requests never touch the macro or the shadow.
              state_q     <= ST_RESP;
              op_q        <= OP_RD;
              rsp_vld_q   <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q     <= ST_SETUP;
              op_q        <= req_wr ? OP_PG : OP_RD;
              cs_q        <= 1'b1;
              adr_q       <= req_addr;
              dati_q      <= req_wr ? req_wdata : '0;
              tmr_start_q <= 1'b1;
              tmr_val_q   <= TW'(T_SETUP);
            end
          end
        end
        ST_SETUP: begin
          if (tmr_done) begin
            tmr_start_q <= 1'b1;
            if (op_q == OP_PG) begin
              state_q   <= ST_PROG;
              pg_q      <= 1'b1;
              tmr_val_q <= TW'(T_PROG);
            end else begin
              state_q   <= ST_READ;
              rd_q      <= 1'b1;
              tmr_val_q <= TW'(T_RD);
            end
          end
        end
        ST_READ: begin
          if (tmr_done) begin
            rd_q     <= 1'b0;
            rdback_q <= OTP_DATO;
            case (op_q)
              OP_BOOT: begin
                idx_q <= idx_q + IW'(1);
                if (32'(idx_q) == SHADOW_N - 1) begin
                  state_q <= ST_BOOT;
                  cs_q    <= 1'b0;
                end else begin
                  state_q     <= ST_SETUP;
                  adr_q       <= AW'(idx_q + IW'(1));
                  tmr_start_q <= 1'b1;
                  tmr_val_q   <= TW'(T_SETUP);
                end
              end
              OP_VF: begin
                if ((OTP_DATO != wdata_q) && (32'(retry_q) < RETRY_MAX)) begin
                  retry_q     <= retry_q + 3'd1;
                  op_q        <= OP_PG;
                  state_q     <= ST_SETUP;
                  tmr_start_q <= 1'b1;
                  tmr_val_q   <= TW'(T_SETUP);
                end else begin
                  state_q     <= ST_RESP;
                  cs_q        <= 1'b0;
                  rsp_vld_q   <= 1'b1;
                  rsp_err_q   <= (OTP_DATO != wdata_q);
                  rsp_rdata_q <= OTP_DATO;
                end
              end
              default: begin
                state_q     <= ST_RESP;
                cs_q        <= 1'b0;
                rsp_vld_q   <= 1'b1;
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= OTP_DATO;
              end
            endcase
          end
        end
        ST_PROG: begin
          if (tmr_done) begin
            state_q <= ST_VERIFY;
            pg_q    <= 1'b0;
          end
        end
        ST_VERIFY: begin
          state_q     <= ST_SETUP;
          op_q        <= OP_VF;
          tmr_start_q <= 1'b1;
          tmr_val_q   <= TW'(T_SETUP);
        end
        ST_RESP: begin
          state_q   <= ST_IDLE;
          req_rdy_q <= 1'b1;
          rsp_err_q <= 1'b0;
          dati_q    <= '0;
        end
        default: state_q <= ST_BOOT;
      endcase
    end
  end

  // Boot captures straight from DO; program results land from the read-back in RESP.
  always_comb begin
    sh_we = '0;
    sh_wd = OTP_DATO;
    if (state_q == ST_READ && op_q == OP_BOOT && tmr_done) begin
      for (int unsigned i = 0; i < SHADOW_N; i++) begin
        if (32'(idx_q) == i) sh_we[i] = 1'b1;
      end
    end else if (state_q == ST_RESP && op_q == OP_VF) begin
      sh_wd = rdback_q;
      for (int unsigned i = 0; i < SHADOW_N; i++) begin
        if (32'(addr_q) == i) sh_we[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (RESET) begin
      shadow_q <= '0;
    end else begin
      for (int unsigned i = 0; i < SHADOW_N; i++) begin
        if (sh_we[i]) shadow_q[i*DW +: DW] <= sh_wd;
      end
    end
  end

  assign req_rdy     = req_rdy_q;
  assign rsp_vld     = rsp_vld_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign boot_done   = boot_done_q;
  assign shadow_data = shadow_q;
  assign OTP_CS      = cs_q;
  assign OTP_READ    = rd_q;
  assign OTP_PROG    = pg_q;
  assign OTP_ADDR    = adr_q;
  assign OTP_DATI    = dati_q;

endmodule
